universal_shift_reg_param: RTL and testbench
============================================

UNIVERSAL_SHIFT_REG_PARAM -- requirements
Module: universal_shift_reg_param

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 Parameter AMT_W, default 4, width of the multi-cycle shift count.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  clock enable; 0 freezes all state except rst.
REQ-007 mode  in  3  0 hold, 1 shift right, 2 shift left, 3 parallel load, 4 rotate right, 5 rotate left, 6 arithmetic shift right, 7 hold.
REQ-008 p_din  in  WIDTH  parallel load data.
REQ-009 s_left_din  in  1  serial input entering at bit 0 on shift left.
REQ-010 s_right_din  in  1  serial input entering at bit WIDTH-1 on shift right.
REQ-011 start  in  1  request a multi-cycle shift of amt steps.
REQ-012 amt  in  AMT_W  step count for start.
REQ-013 p_dout  out  WIDTH  register contents q.
REQ-014 s_left_dout  out  1  equals q[WIDTH-1].
REQ-015 s_right_dout  out  1  equals q[0].
REQ-016 busy  out  1  high while a multi-cycle shift runs.
REQ-017 done  out  1  one-cycle pulse when a multi-cycle shift completes.

Function
REQ-018 Single-step operations SHALL be applied on each edge with en=1, start=0 and FSM in IDLE.
- 1: q <= {s_right_din, q[W-1:1]}
- 2: q <= {q[W-2:0], s_left_din}
- 3: q <= p_din
- 4: q <= {q[0], q[W-1:1]}
- 5: q <= {q[W-2:0], q[W-1]}
- 6: q <= {q[W-1], q[W-1:1]}
- 0/7: q unchanged
REQ-019 The FSM SHALL have two states, IDLE and RUN.
REQ-020 IDLE->RUN SHALL occur on an edge with en=1, start=1, amt!=0, mode in {1,2,4,5,6}.
- mode is latched as op and amt as cnt.
- q is unchanged on that edge.
REQ-021 In RUN, each edge with en=1 SHALL apply op once and decrement cnt.
- Serial inputs are sampled live on each step.
- mode, p_din and start are ignored.
REQ-022 On the RUN edge where cnt==1, the FSM SHALL apply the final step and return to IDLE.
- done=1 for exactly the following cycle.
REQ-023 busy SHALL be 1 exactly while in RUN (registered).
REQ-024 Latency SHALL be as follows: start accepted at edge E0, steps at E1..Eamt, done high between Eamt and Eamt+1.
REQ-025 With en=0 in RUN, q, cnt, op and state SHALL hold.
- busy stays 1.
- Completion is delayed by the number of stalled cycles.
REQ-026 start with amt=0 and a shift mode SHALL leave q unchanged, stay IDLE, and pulse done for one cycle.
REQ-027 start with mode 0/3/7 SHALL be ignored; the single-step operation of REQ-018 is applied.
REQ-028 start asserted on the same edge that done rises SHALL be accepted (back-to-back runs allowed).
REQ-029 A rotate of amt equal to WIDTH SHALL restore the original q.
REQ-030 ASR SHALL saturate to all-sign bits for amt >= WIDTH.
REQ-031 For amt >= WIDTH, logical shifts SHALL end with q equal to the serial-input history (all zeros if the input is held at 0).

Reset
REQ-032 While rst=1, the following SHALL hold immediately, without waiting for a clock edge:
- q=0, hence p_dout=0, s_left_dout=0, s_right_dout=0
- busy=0, done=0
- FSM=IDLE, cnt=0, op=0
REQ-033 Asserting rst during RUN SHALL abort the run with no done pulse.
REQ-034 The first edge after rst deasserts SHALL behave as a normal IDLE edge.

Verification (WIDTH=8, AMT_W=4)
REQ-035 Load: rst pulse, then mode=3, p_din=8'hB5, one edge -> p_dout=8'hB5, s_left_dout=1, s_right_dout=1.
REQ-036 Serial: from 8'hB5, mode=1, s_right_din=0, one edge -> 8'h5A; then mode=2, s_left_din=1, one edge -> 8'hB5.
REQ-037 Rotate run: from 8'hB5, mode=5, start=1, amt=3 at E0.
- busy=1 after E0-E2.
- q=8'hAD and done=1 after E3.
- done=0, busy=0 after E4.
REQ-038 ASR run: load 8'h90, mode=6, start, amt=2 -> 8'hE4 after the second step.
- Repeat with amt=15 -> 8'hFF.
REQ-039 Stall: rotate-right run with amt=8, en=0 for 2 cycles mid-run.
- q is frozen during the stall.
- done arrives 2 cycles late.
- Final q equals the starting value.
REQ-040 Abort: assert rst between edges during a run -> p_dout=0, busy=0 before the next edge, and done is never asserted.

Source files
------------

// File: rtl/universal_shift_reg_param.sv
// Universal shift register: single-step hold/shift/rotate/ASR/load, plus a
// multi-cycle shift engine (IDLE/RUN) that repeats one shift op amt times.
module universal_shift_reg_param #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] p_din,
    input  logic             s_left_din,
    input  logic             s_right_din,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] p_dout,
    output logic             s_left_dout,
    output logic             s_right_dout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             done_q, done_d;

    function automatic logic [WIDTH-1:0] step_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] q,
        input logic             sl_in,
        input logic             sr_in,
        input logic [WIDTH-1:0] pd
    );
        logic [WIDTH-1:0] r;
        r = q;
        case (op)
            3'd1:    r = {sr_in, q[WIDTH-1:1]};
            3'd2:    r = {q[WIDTH-2:0], sl_in};
            3'd3:    r = pd;
            3'd4:    r = {q[0], q[WIDTH-1:1]};
            3'd5:    r = {q[WIDTH-2:0], q[WIDTH-1]};
            3'd6:    r = {q[WIDTH-1], q[WIDTH-1:1]};
            default: r = q;
        endcase
        return r;
    endfunction

    // Only modes that move bits around can be repeated by the run engine.
    function automatic logic is_shift(input logic [2:0] m);
        return (m == 3'd1) || (m == 3'd2) || (m == 3'd4) ||
               (m == 3'd5) || (m == 3'd6);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

    // done is a pulse: it drops on the next edge even while en is low.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        done_d  = 1'b0;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (start && is_shift(mode)) begin
                        if (amt != '0) begin
                            state_d = S_RUN;
                            op_d    = mode;
                            cnt_d   = amt;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        q_d = step_op(mode, q_q, s_left_din, s_right_din, p_din);
                    end
                end
                S_RUN: begin
                    q_d   = step_op(op_q, q_q, s_left_din, s_right_din, p_din);
                    cnt_d = cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        p_dout       = q_q;
        s_left_dout  = q_q[WIDTH-1];
        s_right_dout = q_q[0];
        busy         = (state_q == S_RUN);
        done         = done_q;
    end

endmodule

// File: tb/tb_universal_shift_reg_param.sv
// Directed bench for universal_shift_reg_param (WIDTH=8, AMT_W=4): the driver
// queues the expected outputs per edge, a monitor pops and compares after it.
module tb_universal_shift_reg_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] p_din;
  logic       s_left_din;
  logic       s_right_din;
  logic       start;
  logic [3:0] amt;
  logic [7:0] p_dout;
  logic       s_left_dout;
  logic       s_right_dout;
  logic       busy;
  logic       done;

  logic [11:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  universal_shift_reg_param #(.WIDTH(8), .AMT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .p_din(p_din),
    .s_left_din(s_left_din), .s_right_din(s_right_din),
    .start(start), .amt(amt), .p_dout(p_dout),
    .s_left_dout(s_left_dout), .s_right_dout(s_right_dout),
    .busy(busy), .done(done)
  );

  wire [11:0] act = {done, busy, s_right_dout, s_left_dout, p_dout};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] pk(input logic [7:0] q, input logic b, input logic d);
    return {d, b, q[0], q[7], q};
  endfunction

  task automatic check(input string n, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got done/busy/sr/sl/q=%h expected %h", n, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      logic [11:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, act, e);
    end
  end

  task automatic cyc(input logic e, input logic [2:0] m, input logic [7:0] pd,
                     input logic sl, input logic sr, input logic st, input logic [3:0] a,
                     input logic [7:0] eq, input logic eb, input logic ed, input string n);
    @(negedge clk);
    en = e; mode = m; p_din = pd; s_left_din = sl; s_right_din = sr;
    start = st; amt = a;
    exp_q.push_back(pk(eq, eb, ed));
    name_q.push_back(n);
    @(posedge clk);
  endtask

  logic [7:0] asr15_tbl [15] = '{8'hF2, 8'hF9, 8'hFC, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] ror_tbl [8]   = '{8'hE2, 8'h71, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'h8B, 8'hC5};
  logic [7:0] shr_tbl [10]  = '{8'h62, 8'h31, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h01, 8'h00,
                                8'h00, 8'h00};

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'd0; p_din = 8'h00;
    s_left_din = 1'b0; s_right_din = 1'b0; start = 1'b0; amt = 4'd0;
    #3;
    check("reset_state", act, pk(8'h00, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;

    // single-step operations
    cyc(1, 3'd3, 8'hB5, 0, 0, 0, 4'd0, 8'hB5, 0, 0, "load_b5");
    cyc(1, 3'd1, 8'h00, 0, 0, 0, 4'd0, 8'h5A, 0, 0, "shr_step");
    cyc(1, 3'd2, 8'h00, 1, 0, 0, 4'd0, 8'hB5, 0, 0, "shl_step");
    cyc(1, 3'd7, 8'h00, 1, 1, 0, 4'd0, 8'hB5, 0, 0, "hold_7");

    // rotate-left run of 3; mode/p_din/start during RUN must be ignored
    cyc(1, 3'd5, 8'h00, 0, 0, 1, 4'd3, 8'hB5, 1, 0, "rol_e0");
    cyc(1, 3'd3, 8'h00, 0, 0, 1, 4'd0, 8'h6B, 1, 0, "rol_e1");
    cyc(1, 3'd3, 8'h00, 0, 0, 0, 4'd0, 8'hD6, 1, 0, "rol_e2");
    cyc(1, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'hAD, 0, 1, "rol_e3");
    cyc(1, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'hAD, 0, 0, "rol_e4");

    // ASR run of 2, then back-to-back ASR run of 15 accepted while done is high
    cyc(1, 3'd3, 8'h90, 0, 0, 0, 4'd0, 8'h90, 0, 0, "load_90");
    cyc(1, 3'd6, 8'h00, 0, 0, 1, 4'd2, 8'h90, 1, 0, "asr2_e0");
    cyc(1, 3'd6, 8'h00, 0, 0, 0, 4'd0, 8'hC8, 1, 0, "asr2_e1");
    cyc(1, 3'd6, 8'h00, 0, 0, 0, 4'd0, 8'hE4, 0, 1, "asr2_e2");
    cyc(1, 3'd6, 8'h00, 0, 0, 1, 4'd15, 8'hE4, 1, 0, "asr15_e0");
    for (int i = 0; i < 15; i++)
      cyc(1, 3'd0, 8'h00, 0, 0, 0, 4'd0, asr15_tbl[i], (i != 14), (i == 14), "asr15_step");
    cyc(1, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'hFF, 0, 0, "asr15_after");

    // amt=0 start: no change, no run, single done pulse
    cyc(1, 3'd1, 8'h00, 0, 0, 1, 4'd0, 8'hFF, 0, 1, "amt0");
    cyc(1, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'hFF, 0, 0, "amt0_after");

    // start with a non-shift mode is ignored and the load happens
    cyc(1, 3'd3, 8'hC5, 0, 0, 1, 4'd5, 8'hC5, 0, 0, "start_load");

    // rotate-right by WIDTH with a 2-cycle stall after step 3
    cyc(1, 3'd4, 8'h00, 0, 0, 1, 4'd8, 8'hC5, 1, 0, "ror8_e0");
    for (int i = 0; i < 3; i++)
      cyc(1, 3'd0, 8'h00, 0, 0, 0, 4'd0, ror_tbl[i], 1, 0, "ror8_step");
    cyc(0, 3'd3, 8'hAA, 1, 1, 1, 4'd3, 8'hB8, 1, 0, "ror8_stall");
    cyc(0, 3'd3, 8'hAA, 1, 1, 1, 4'd3, 8'hB8, 1, 0, "ror8_stall");
    for (int i = 3; i < 8; i++)
      cyc(1, 3'd0, 8'h00, 0, 0, 0, 4'd0, ror_tbl[i], (i != 7), (i == 7), "ror8_step");
    cyc(1, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'hC5, 0, 0, "ror8_after");

    // logical shift right by 10 > WIDTH with serial input held at 0
    cyc(1, 3'd1, 8'h00, 0, 0, 1, 4'd10, 8'hC5, 1, 0, "shr10_e0");
    for (int i = 0; i < 10; i++)
      cyc(1, 3'd0, 8'h00, 0, 0, 0, 4'd0, shr_tbl[i], (i != 9), (i == 9), "shr10_step");

    // en=0 in IDLE freezes q
    cyc(0, 3'd3, 8'hAA, 0, 0, 0, 4'd0, 8'h00, 0, 0, "en0_idle");

    // abort a rotate-right run with an asynchronous reset between edges
    cyc(1, 3'd3, 8'h81, 0, 0, 0, 4'd0, 8'h81, 0, 0, "load_81");
    cyc(1, 3'd4, 8'h00, 0, 0, 1, 4'd5, 8'h81, 1, 0, "abort_e0");
    cyc(1, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'hC0, 1, 0, "abort_e1");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_async", act, pk(8'h00, 1'b0, 1'b0));
    @(negedge clk);
    check("abort_held", act, pk(8'h00, 1'b0, 1'b0));
    rst = 1'b0;
    cyc(1, 3'd4, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0, "abort_no_done");
    cyc(1, 3'd3, 8'h3C, 0, 0, 0, 4'd0, 8'h3C, 0, 0, "post_rst_load");
    cyc(1, 3'd2, 8'h00, 1, 0, 0, 4'd0, 8'h79, 0, 0, "post_rst_shl");

    repeat (3) @(posedge clk);
    #3;
    check("queue_drain", 12'(exp_q.size()), 12'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
